// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared AXI4-Lite response codes and read-arbiter state encoding
package axi4lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way picker, round-robin or port-1 priority on a tie
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic       win
);

    // A single requester always wins; only a tie consults the policy.
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = prio_mode ? 1'b1 : ~last;
        end
    end

endmodule

// File: rtl/axi4lite_read_arbiter.sv
// rtl/axi4lite_read_arbiter.sv - shares one AXI4-Lite read slave between fetch (port 0) and data (port 1)
module axi4lite_read_arbiter
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DATA_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              grant,
    output logic              busy
);

    localparam logic PRIO_MODE = (DATA_PRIO != 0);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_grant;
    logic       r_last_grant;
    logic       w_win;
    logic       w_any_req;
    logic       w_r_done;

    assign w_any_req = m0_arvalid | m1_arvalid;
    assign w_r_done  = (r_state == DATA) && s_rvalid &&
                       (r_grant ? m1_rready : m0_rready);

    rr_arbiter2 u_rr_arbiter2 (
        .req       ({m1_arvalid, m0_arvalid}),
        .last      (r_last_grant),
        .prio_mode (PRIO_MODE),
        .win       (w_win)
    );

    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_any_req) begin
                r_grant <= w_win;
            end
            if (w_r_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = OKAY;
        m1_rresp   = OKAY;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                s_arvalid  = 1'b1;
                s_araddr   = r_grant ? m1_araddr : m0_araddr;
                m0_arready = ~r_grant & s_arready;
                m1_arready = r_grant & s_arready;
                if (s_arready) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                // Both ports see the slave data; only the granted one sees rvalid.
                m0_rdata  = s_rdata;
                m1_rdata  = s_rdata;
                m0_rresp  = s_rresp;
                m1_rresp  = s_rresp;
                m0_rvalid = ~r_grant & s_rvalid;
                m1_rvalid = r_grant & s_rvalid;
                s_rready  = r_grant ? m1_rready : m0_rready;
                if (w_r_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign grant = r_grant;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_axi4lite_read_arbiter.sv
// tb/tb_axi4lite_read_arbiter.sv - scoreboard bench for the two-port AXI4-Lite read arbiter
module tb_axi4lite_read_arbiter;
    import axi4lite_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        int          ard;
        int          rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, grant, busy;

    logic [31:0] p_m0_araddr, p_m1_araddr, p_m0_rdata, p_m1_rdata, p_s_araddr, p_s_rdata;
    logic        p_m0_arvalid, p_m0_arready, p_m0_rvalid, p_m0_rready;
    logic        p_m1_arvalid, p_m1_arready, p_m1_rvalid, p_m1_rready;
    logic [1:0]  p_m0_rresp, p_m1_rresp, p_s_rresp;
    logic        p_s_arvalid, p_s_arready, p_s_rvalid, p_s_rready, p_grant, p_busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  slv_resp = OKAY;
    logic [31:0] slv_addr = '0;
    logic [31:0] req_q0[$], req_q1[$];
    exp_t        exp_q0[$], exp_q1[$];
    int          order_q[$];
    logic        hs0 = 1'b0, hs1 = 1'b0;
    int          issue0 = 0, issue1 = 0, rsp0 = 0, rsp1 = 0, ar_cyc = 0, arr1_first = -1;
    logic [31:0] ar_addr_log = '0;

    axi4lite_read_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    axi4lite_read_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1)) dut_prio (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(p_m0_araddr), .m0_arvalid(p_m0_arvalid), .m0_arready(p_m0_arready),
        .m0_rdata(p_m0_rdata), .m0_rresp(p_m0_rresp), .m0_rvalid(p_m0_rvalid), .m0_rready(p_m0_rready),
        .m1_araddr(p_m1_araddr), .m1_arvalid(p_m1_arvalid), .m1_arready(p_m1_arready),
        .m1_rdata(p_m1_rdata), .m1_rresp(p_m1_rresp), .m1_rvalid(p_m1_rvalid), .m1_rready(p_m1_rready),
        .s_araddr(p_s_araddr), .s_arvalid(p_s_arvalid), .s_arready(p_s_arready),
        .s_rdata(p_s_rdata), .s_rresp(p_s_rresp), .s_rvalid(p_s_rvalid), .s_rready(p_s_rready),
        .grant(p_grant), .busy(p_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h1111_1111;
            32'h80:  return 32'h2222_2222;
            32'h10:  return 32'hDEAD_BEEF;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Slave model: configurable address and data wait states.
    initial forever begin
        @(posedge clk);
        #1;
        if (s_arvalid) begin
            if (ar_wait < ar_delay) begin
                s_arready = 1'b0;
                ar_wait++;
            end else begin
                s_arready = 1'b1;
                slv_addr  = s_araddr;
            end
        end else begin
            s_arready = 1'b0;
            ar_wait   = 0;
        end
        if (busy && !s_arvalid) begin
            if (r_wait < r_delay) begin
                s_rvalid = 1'b0;
                r_wait++;
            end else begin
                s_rvalid = 1'b1;
                s_rdata  = mem_f(slv_addr);
                s_rresp  = slv_resp;
            end
        end else begin
            s_rvalid = 1'b0;
            r_wait   = 0;
        end
    end

    // Masters: issue queued addresses, hold arvalid/araddr until handshake.
    initial forever begin
        @(posedge clk);
        #1;
        if (m0_arvalid && hs0) begin
            m0_arvalid = 1'b0;
            void'(req_q0.pop_front());
        end
        if (!m0_arvalid && req_q0.size() > 0) begin
            m0_arvalid = 1'b1;
            m0_araddr  = req_q0[0];
            issue0     = cyc;
        end
        if (m1_arvalid && hs1) begin
            m1_arvalid = 1'b0;
            void'(req_q1.pop_front());
        end
        if (!m1_arvalid && req_q1.size() > 0) begin
            m1_arvalid = 1'b1;
            m1_araddr  = req_q1[0];
            issue1     = cyc;
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        hs0 = m0_arvalid && m0_arready;
        hs1 = m1_arvalid && m1_arready;
        if (s_arvalid && s_arready) begin
            ar_addr_log = s_araddr;
            ar_cyc      = cyc;
        end
        if (m1_arready && arr1_first < 0) arr1_first = cyc;
        if (busy && s_arvalid) check("arvalid_held", 32'(grant ? m1_arvalid : m0_arvalid), 32'd1);
        check("rvalid_exclusive", 32'(m0_rvalid & m1_rvalid), 32'd0);
        if (m0_rvalid && m0_rready) begin
            if (exp_q0.size() == 0) begin
                check("m0_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                check("m0_rdata", m0_rdata, e.data);
                check("m0_rresp", 32'(m0_rresp), 32'(e.resp));
            end
            rsp0 = cyc;
            order_q.push_back(0);
        end
        if (m1_rvalid && m1_rready) begin
            if (exp_q1.size() == 0) begin
                check("m1_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                check("m1_rdata", m1_rdata, e.data);
                check("m1_rresp", 32'(m1_rresp), 32'(e.resp));
            end
            rsp1 = cyc;
            order_q.push_back(1);
        end
    end

    task automatic push_req(input logic port, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp);
        exp_t e;
        e.data = data;
        e.resp = resp;
        if (port) begin
            exp_q1.push_back(e);
            req_q1.push_back(addr);
        end else begin
            exp_q0.push_back(e);
            req_q0.push_back(addr);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q0.size() == 0 && exp_q1.size() == 0 && req_q0.size() == 0 &&
                 req_q1.size() == 0 && !busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_data(input string name);
        int n = 0;
        while (!(busy && !s_arvalid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach_data"}, 32'(n < 100), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int   exp_ord[4];
        int   n;
        int   cnt;
        vecs[0] = '{port: 1'b0, addr: 32'h10, ard: 0, rd: 0, resp: OKAY,   data: 32'hDEAD_BEEF};
        vecs[1] = '{port: 1'b1, addr: 32'h80, ard: 0, rd: 0, resp: OKAY,   data: 32'h2222_2222};
        vecs[2] = '{port: 1'b1, addr: 32'h44, ard: 3, rd: 4, resp: SLVERR, data: 32'hA5A5_0044};
        vecs[3] = '{port: 1'b0, addr: 32'h00, ard: 1, rd: 2, resp: OKAY,   data: 32'h1111_1111};
        vecs[4] = '{port: 1'b0, addr: 32'h20, ard: 0, rd: 1, resp: SLVERR, data: 32'hA5A5_0020};
        exp_ord = '{0, 1, 0, 1};

        rst_n = 1'b0;
        m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = OKAY;
        p_m0_araddr = 32'h100; p_m0_arvalid = 1'b0; p_m0_rready = 1'b1;
        p_m1_araddr = 32'h200; p_m1_arvalid = 1'b0; p_m1_rready = 1'b1;
        p_s_arready = 1'b1; p_s_rvalid = 1'b1; p_s_rdata = 32'h3333_3333; p_s_rresp = OKAY;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_arvalid", 32'(s_arvalid), 32'd0);
        check("rst_s_rready", 32'(s_rready), 32'd0);
        check("rst_arready", 32'({m0_arready, m1_arready}), 32'd0);
        check("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            ar_delay = vecs[i].ard;
            r_delay  = vecs[i].rd;
            slv_resp = vecs[i].resp;
            push_req(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].resp);
            wait_idle("vec");
            check("vec_araddr", ar_addr_log, vecs[i].addr);
            check("vec_ar_latency", 32'(ar_cyc - (vecs[i].port ? issue1 : issue0)), 32'(1 + vecs[i].ard));
            check("vec_r_latency", 32'((vecs[i].port ? rsp1 : rsp0) - (vecs[i].port ? issue1 : issue0)),
                  32'(2 + vecs[i].ard + vecs[i].rd));
        end
        ar_delay = 0; r_delay = 0; slv_resp = OKAY;

        apply_reset();
        order_q.delete();
        push_req(1'b0, 32'h00, 32'h1111_1111, OKAY);
        push_req(1'b0, 32'h00, 32'h1111_1111, OKAY);
        push_req(1'b1, 32'h80, 32'h2222_2222, OKAY);
        push_req(1'b1, 32'h80, 32'h2222_2222, OKAY);
        wait_idle("tie");
        check("tie_count", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) check("tie_order", 32'(order_q[i]), 32'(exp_ord[i]));

        r_delay = 2;
        push_req(1'b0, 32'h10, 32'hDEAD_BEEF, OKAY);
        wait_data("late");
        arr1_first = -1;
        push_req(1'b1, 32'h80, 32'h2222_2222, OKAY);
        wait_idle("late");
        check("late_arready_gap", 32'(arr1_first - rsp0), 32'd2);
        r_delay = 0;

        ar_delay = 3; r_delay = 4; slv_resp = SLVERR;
        m1_rready = 1'b0;
        push_req(1'b1, 32'h80, 32'h2222_2222, SLVERR);
        n = 0;
        cnt = 0;
        while (!m1_rvalid && n < 40) begin
            @(negedge clk);
            n++;
            if (s_arvalid) begin
                cnt++;
                check("stall_araddr", s_araddr, 32'h80);
            end
        end
        check("stall_rvalid_seen", 32'(n < 40), 32'd1);
        check("stall_addr_cycles", 32'(cnt), 32'd4);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_hold_rvalid", 32'(m1_rvalid), 32'd1);
            check("stall_hold_busy", 32'(busy), 32'd1);
            check("stall_hold_s_rready", 32'(s_rready), 32'd0);
        end
        @(posedge clk);
        #1;
        m1_rready = 1'b1;
        wait_idle("stall");
        ar_delay = 0; r_delay = 0; slv_resp = OKAY;

        r_delay = 10;
        req_q1.push_back(32'h40);
        wait_data("rstmid");
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_s_rready", 32'(s_rready), 32'd0);
        check("rstmid_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("rstmid_s_arvalid", 32'(s_arvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r_delay = 0;
        #1;
        check("rstmid_post_grant", 32'(grant), 32'd0);
        check("rstmid_post_busy", 32'(busy), 32'd0);
        push_req(1'b0, 32'h00, 32'h1111_1111, OKAY);
        wait_idle("rstmid_fresh");

        @(posedge clk);
        #1;
        p_m0_arvalid = 1'b1;
        p_m1_arvalid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("prio_m0_arready", 32'(p_m0_arready), 32'd0);
            if (p_m1_arready) cnt++;
            if (p_busy) check("prio_grant", 32'(p_grant), 32'd1);
            if (p_m1_rvalid) check("prio_m1_rdata", p_m1_rdata, 32'h3333_3333);
        end
        check("prio_m1_count", 32'(cnt), 32'd10);
        p_m0_arvalid = 1'b0;
        p_m1_arvalid = 1'b0;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
